// File: rtl/gradient_xy_pipe.sv
// rtl/gradient_xy_pipe.sv - Prewitt-style KxK gradient engine with valid/ready backpressure
//
// Turns a KxK pixel window into Gx/Gy gradients. Each output field is raw signed,
// absolute, or the L1 magnitude, and is saturated to OUT_WIDTH. The block is a
// three-register pipeline: per-line weighted sums, then totals, then mode
// transform and clamp. A single global enable stalls every stage at once.
//
// Ports
//   i_clk      clock
//   i_aresetn  asynchronous active-low reset
//   i_window   pixel window [row][col], row 0 = top, col 0 = left
//   i_valid    window valid
//   i_sof      first window of a frame (qualified by i_valid)
//   i_mode     00 raw signed, 01 abs, 10 L1 magnitude, 11 same as 00
//   o_ready    upstream may present the next beat
//   o_vector   {Gy field, Gx field}, OUT_WIDTH bits each
//   o_valid    o_vector valid
//   o_sof      marks the beat that entered with i_sof
//   i_ready    downstream accepts
//   o_sat      sticky: some beat of the current output frame was clamped
//
// OUT_WIDTH may be narrower than the internal width. Results are then clamped,
// and o_sat records the clamp.
module gradient_xy_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_aresetn,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] i_window,
  input  logic                                                  i_valid,
  input  logic                                                  i_sof,
  input  logic [1:0]                                            i_mode,
  output logic                                                  o_ready,
  output logic [2*OUT_WIDTH-1:0]                                o_vector,
  output logic                                                  o_valid,
  output logic                                                  o_sof,
  input  logic                                                  i_ready,
  output logic                                                  o_sat
);
  localparam int K  = KERNEL_SIZE;
  localparam int H  = K / 2;
  localparam int IW = DATA_WIDTH + $clog2(K * (K * K - 1) / 4) + 1;
  // Clamp arithmetic width: wide enough for |Gx|+|Gy| and for the output limits.
  localparam int CW = ((OUT_WIDTH > IW) ? OUT_WIDTH : IW) + 2;
  localparam logic signed [CW-1:0] SMAX = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN = ~SMAX;
  localparam logic signed [CW-1:0] UMAX = {{(CW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  if (KERNEL_SIZE != 3 && KERNEL_SIZE != 5) begin : g_bad_kernel
    $error("KERNEL_SIZE must be 3 or 5");
  end
  if (OUT_WIDTH < 2) begin : g_bad_width
    $error("OUT_WIDTH must be at least 2");
  end

  // Map a non-centre index j (0..K-2) to its row/column position; the centre is skipped.
  function automatic int pos(input int j);
    return (j < H) ? j : j + 1;
  endfunction

  logic       ce, accept;
  logic [1:0] frame_mode, in_mode, beat_mode;

  assign ce      = i_ready | ~o_valid;
  assign o_ready = ce;
  assign accept  = i_valid & ce;

  // The sof beat uses its own mode; later beats of the frame use the latched one.
  always_comb begin
    in_mode   = (i_mode == 2'b11) ? 2'b00 : i_mode;
    beat_mode = i_sof ? in_mode : frame_mode;
  end

  // S1 combinational: weighted column sums (Gx) and weighted row sums (Gy).
  logic signed [IW-1:0] x_sum [K-1];
  logic signed [IW-1:0] y_sum [K-1];
  logic signed [IW-1:0] x_acc, y_acc;
  always_comb begin
    x_acc = '0;
    y_acc = '0;
    for (int j = 0; j < K - 1; j++) begin
      x_acc = '0;
      y_acc = '0;
      for (int i = 0; i < K; i++) begin
        x_acc = x_acc + IW'(i_window[i][pos(j)]);
        y_acc = y_acc + IW'(i_window[pos(j)][i]);
      end
      x_sum[j] = x_acc * IW'(pos(j) - H);
      y_sum[j] = y_acc * IW'(H - pos(j));
    end
  end

  logic signed [IW-1:0] s1_x [K-1];
  logic signed [IW-1:0] s1_y [K-1];
  logic                 s1_valid, s1_sof;
  logic [1:0]           s1_mode;

  // S2 combinational: totals.
  logic signed [IW-1:0] gx_tot, gy_tot;
  always_comb begin
    gx_tot = '0;
    gy_tot = '0;
    for (int j = 0; j < K - 1; j++) begin
      gx_tot = gx_tot + s1_x[j];
      gy_tot = gy_tot + s1_y[j];
    end
  end

  logic signed [IW-1:0] s2_gx, s2_gy;
  logic                 s2_valid, s2_sof;
  logic [1:0]           s2_mode;

  // S3 combinational: mode transform and saturation.
  logic signed [CW-1:0]   ex, ey, ax, ay, l1;
  logic [OUT_WIDTH-1:0]   fx, fy;
  logic                   clamp;
  always_comb begin
    ex    = CW'(s2_gx);
    ey    = CW'(s2_gy);
    ax    = (ex < 0) ? -ex : ex;
    ay    = (ey < 0) ? -ey : ey;
    l1    = ax + ay;
    fx    = '0;
    fy    = '0;
    clamp = 1'b0;
    case (s2_mode)
      2'b01: begin
        fx    = OUT_WIDTH'((ax > UMAX) ? UMAX : ax);
        fy    = OUT_WIDTH'((ay > UMAX) ? UMAX : ay);
        clamp = (ax > UMAX) || (ay > UMAX);
      end
      2'b10: begin
        fx    = OUT_WIDTH'((l1 > UMAX) ? UMAX : l1);
        clamp = (l1 > UMAX);
      end
      default: begin
        fx    = OUT_WIDTH'((ex > SMAX) ? SMAX : ((ex < SMIN) ? SMIN : ex));
        fy    = OUT_WIDTH'((ey > SMAX) ? SMAX : ((ey < SMIN) ? SMIN : ey));
        clamp = (ex > SMAX) || (ex < SMIN) || (ey > SMAX) || (ey < SMIN);
      end
    endcase
  end

  logic out_clamp;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      frame_mode <= 2'b00;
      for (int j = 0; j < K - 1; j++) begin
        s1_x[j] <= '0;
        s1_y[j] <= '0;
      end
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_mode   <= 2'b00;
      s2_gx     <= '0;
      s2_gy     <= '0;
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_mode   <= 2'b00;
      o_vector  <= '0;
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      out_clamp <= 1'b0;
      o_sat     <= 1'b0;
    end else begin
      if (accept && i_sof) begin
        frame_mode <= in_mode;
      end
      if (ce) begin
        s1_x      <= x_sum;
        s1_y      <= y_sum;
        s1_valid  <= i_valid;
        s1_sof    <= i_valid & i_sof;
        s1_mode   <= beat_mode;
        s2_gx     <= gx_tot;
        s2_gy     <= gy_tot;
        s2_valid  <= s1_valid;
        s2_sof    <= s1_sof;
        s2_mode   <= s1_mode;
        o_vector  <= {fy, fx};
        o_valid   <= s2_valid;
        o_sof     <= s2_sof;
        out_clamp <= clamp;
      end
      // The flag restarts with each frame's first beat as it leaves.
      if (o_valid && i_ready) begin
        o_sat <= o_sof ? out_clamp : (o_sat | out_clamp);
      end
    end
  end

endmodule
